// File: rtl/decode_pkg.sv
// Shared opcode/mode encodings, FSM states and the default-width decoded word
// for the instruction-decode stage.
package decode_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OP_W    = 5;
  localparam int DEF_MODE_W  = 2;
  localparam int DEF_NUM_OPS = 16;
  localparam int DEF_MODE_N  = 2 ** DEF_MODE_W;
  localparam int DEF_OPND_W  = DEF_INSTR_W - DEF_OP_W - DEF_MODE_W;

  typedef enum logic [DEF_OP_W-1:0] {
    OP_NOP = 5'd0, OP_STA, OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
    OP_J, OP_JN, OP_JZ, OP_IN, OP_OUT, OP_SHR, OP_SHL, OP_HLT
  } opcode_e;

  typedef enum logic [DEF_MODE_W-1:0] {
    MODE_DIR = 2'd0, MODE_IND, MODE_IM, MODE_SOP
  } mode_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } stageState_e;

  typedef struct packed {
    logic [DEF_NUM_OPS-1:0] op;
    logic [DEF_MODE_N-1:0]  mode;
    logic [DEF_OPND_W-1:0]  operand;
    logic                   illegal;
  } decoded_t;

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry valid/ready skid buffer (output register + spare entry), strict FIFO order.
// Latency: 1 cycle input to output. Backpressure: inRdy = spare empty, purely from registers.
// Output holds stable while outVld & !outRdy.
module decode_skid_buf
  import decode_pkg::*;
#(
  parameter type T = decoded_t
) (
  input  logic clock,
  input  logic reset,
  input  logic inVld,
  output logic inRdy,
  input  T     inDat,
  output logic outVld,
  input  logic outRdy,
  output T     outDat
);

  logic spVld;
  T     spDat;
  logic push;
  logic pop;

  assign inRdy = ~spVld;
  assign push  = inVld & inRdy;
  assign pop   = outVld & outRdy;

  always_ff @(posedge clock) begin
    if (reset) begin
      outVld <= 1'b0;
      spVld  <= 1'b0;
      outDat <= '0;
      spDat  <= '0;
    end else if (!outVld || pop) begin
      // Output slot frees up: the older spare word goes first, the new word refills the spare.
      if (spVld) begin
        outDat <= spDat;
        outVld <= 1'b1;
        spVld  <= push;
        if (push) spDat <= inDat;
      end else begin
        outVld <= push;
        if (push) outDat <= inDat;
      end
    end else if (push) begin
      spDat <= inDat;
      spVld <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: splits the word into one-hot opcode/mode + operand; HLT freezes intake until resume.
// Latency 1 cycle; in_ready registered (spare empty & RUN), no path from out_ready.
// Optional accept/illegal statistics counters under DECODE_STATS_EN.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int MODE_W  = 2,
  parameter int NUM_OPS = 16,
  parameter int HLT_OP  = 15
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INSTR_W-1:0]              in_instr,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_OPS-1:0]              out_op,
  output logic [2**MODE_W-1:0]            out_mode,
  output logic [INSTR_W-OP_W-MODE_W-1:0]  out_operand,
  output logic                            out_illegal,
  output logic                            halted,
  input  logic                            resume,
  output logic [31:0]                     stat_instr,
  output logic [15:0]                     stat_illegal
);

  localparam int MODE_N = 2 ** MODE_W;
  localparam int OPND_W = INSTR_W - OP_W - MODE_W;

  typedef struct packed {
    logic [NUM_OPS-1:0] op;
    logic [MODE_N-1:0]  mode;
    logic [OPND_W-1:0]  operand;
    logic               illegal;
  } stageWord_t;

  logic [OP_W-1:0]   opcode;
  logic [MODE_W-1:0] mode;
  stageWord_t        dec;
  stageWord_t        held;
  stageState_e       state;
  stageState_e       nextState;
  logic              run;
  logic              bufRdy;
  logic              accept;
  logic              isHlt;

  assign opcode = in_instr[INSTR_W-1 -: OP_W];
  assign mode   = in_instr[INSTR_W-OP_W-1 -: MODE_W];

  // Opcode k maps to the MSB-first bit NUM_OPS-1-k; same for modes.
  always_comb begin
    dec         = '0;
    dec.illegal = int'(opcode) >= NUM_OPS;
    dec.operand = in_instr[OPND_W-1:0];
    for (int k = 0; k < NUM_OPS; k++) dec.op[NUM_OPS-1-k] = (int'(opcode) == k);
    for (int m = 0; m < MODE_N; m++) dec.mode[MODE_N-1-m] = (int'(mode) == m);
  end

  assign isHlt    = ~dec.illegal & (int'(opcode) == HLT_OP);
  assign run      = (state == RUN);
  assign halted   = (state == HALTED);
  assign in_ready = bufRdy & run;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      RUN:     if (accept && isHlt) nextState = HALTED;
      HALTED:  if (resume) nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  decode_skid_buf #(
    .T(stageWord_t)
  ) u_skid (
    .clock  (clock),
    .reset  (reset),
    .inVld  (in_valid & run),
    .inRdy  (bufRdy),
    .inDat  (dec),
    .outVld (out_valid),
    .outRdy (out_ready),
    .outDat (held)
  );

  assign out_op      = held.op;
  assign out_mode    = held.mode;
  assign out_operand = held.operand;
  assign out_illegal = held.illegal;

`ifdef DECODE_STATS_EN
  logic [31:0] instrCnt;
  logic [15:0] illegalCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      instrCnt   <= '0;
      illegalCnt <= '0;
    end else if (accept) begin
      instrCnt <= instrCnt + 32'd1;
      if (dec.illegal && illegalCnt != 16'hFFFF) illegalCnt <= illegalCnt + 16'd1;
    end
  end

  assign stat_instr   = instrCnt;
  assign stat_illegal = illegalCnt;
`else
  assign stat_instr   = '0;
  assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized + directed bench for instr_decode_stage against a queue-based behavioural model.
module tb_instr_decode_stage;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_op;
  logic [3:0]  out_mode;
  logic [8:0]  out_operand;
  logic        out_illegal;
  logic        halted;
  logic        resume;
  logic [31:0] stat_instr;
  logic [15:0] stat_illegal;

  instr_decode_stage dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op       (out_op),
    .out_mode     (out_mode),
    .out_operand  (out_operand),
    .out_illegal  (out_illegal),
    .halted       (halted),
    .resume       (resume),
    .stat_instr   (stat_instr),
    .stat_illegal (stat_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: queue of raw accepted words awaiting transfer, halt flag, counters.
  logic [15:0] mq[$];
  bit          mHalt = 0;
  int unsigned mInstr = 0;
  int unsigned mIll = 0;
  bit          lastAcc = 0;
  bit          capOn = 0;
  logic [15:0] capQ[$];

  function automatic int unsigned fOpc(input logic [15:0] w);
    return int'(w) / 2048;
  endfunction
  function automatic logic [15:0] expOp(input logic [15:0] w);
    int unsigned o = fOpc(w);
    return (o < 16) ? 16'(1 << (15 - o)) : 16'h0;
  endfunction
  function automatic logic [3:0] expMode(input logic [15:0] w);
    int unsigned m = (int'(w) / 512) % 4;
    return 4'(1 << (3 - m));
  endfunction
  function automatic logic [8:0] expOperand(input logic [15:0] w);
    return 9'(int'(w) % 512);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    logic [31:0] eInstr;
    logic [31:0] eIll;
`ifdef DECODE_STATS_EN
    eInstr = mInstr;
    eIll   = mIll;
`else
    eInstr = 0;
    eIll   = 0;
`endif
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(!mHalt && mq.size() < 2));
    chk("halted", 32'(halted), 32'(mHalt));
    chk("stat_instr", stat_instr, eInstr);
    chk("stat_illegal", 32'(stat_illegal), eIll);
    if (mq.size() > 0) begin
      chk("out_op", 32'(out_op), 32'(expOp(mq[0])));
      chk("out_mode", 32'(out_mode), 32'(expMode(mq[0])));
      chk("out_operand", 32'(out_operand), 32'(expOperand(mq[0])));
      chk("out_illegal", 32'(out_illegal), 32'(fOpc(mq[0]) >= 16));
    end
  endtask

  task automatic updateModel(input bit v, input logic [15:0] ins, input bit ordy, input bit res);
    bit rdy  = !mHalt && mq.size() < 2;
    bit acc  = v && rdy;
    bit xfer = (mq.size() > 0) && ordy;
    if (xfer) void'(mq.pop_front());
    if (acc) mq.push_back(ins);
    if (mHalt) begin
      if (res) mHalt = 0;
    end else if (acc && fOpc(ins) == 15) begin
      mHalt = 1;
    end
    if (acc) begin
      mInstr++;
      if (fOpc(ins) >= 16 && mIll < 65535) mIll++;
    end
    lastAcc = acc;
  endtask

  // Called at a negedge: check, drive the next cycle's inputs, advance the model, wait a cycle.
  task automatic cycle(input bit v, input logic [15:0] ins, input bit ordy, input bit res);
    compareModel();
    if (capOn && out_valid && ordy) capQ.push_back(out_op);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    resume    = res;
    updateModel(v, ins, ordy, res);
    @(negedge clock);
  endtask

  task automatic doReset(input int n);
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    resume    = 1'b0;
    repeat (n) @(negedge clock);
    reset  = 1'b0;
    mq.delete();
    mHalt  = 0;
    mInstr = 0;
    mIll   = 0;
  endtask

  task automatic sendUntilAccepted(input logic [15:0] w, input bit ordy);
    int n = 0;
    do begin
      cycle(1, w, ordy, 0);
      n++;
    end while (!lastAcc && n < 20);
    chk("send_timeout", 32'(lastAcc), 32'd1);
  endtask

  logic [15:0] stream[4] = '{16'h0801, 16'h1002, 16'h2003, 16'h2804};
  logic [15:0] drainExp[4] = '{16'h4000, 16'h2000, 16'h0800, 16'h0400};

  initial begin
    // 1. reset
    doReset(3);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 2. single ADD IND 5
    cycle(1, 16'h1A05, 1, 0);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op", 32'(out_op), 32'h1000);
    chk("add_mode", 32'(out_mode), 32'h4);
    chk("add_operand", 32'(out_operand), 32'd5);
    chk("add_illegal", 32'(out_illegal), 32'd0);
    cycle(0, 16'h0, 1, 0);

    // 3. stream with stalled output, then drain
    cycle(1, stream[0], 0, 0);
    cycle(1, stream[1], 0, 0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_op", 32'(out_op), 32'h4000);
    cycle(1, stream[2], 0, 0);
    chk("stall_hold_op", 32'(out_op), 32'h4000);
    chk("stall_hold_rdy", 32'(in_ready), 32'd0);
    capOn = 1;
    sendUntilAccepted(stream[2], 1);
    sendUntilAccepted(stream[3], 1);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0);
    capOn = 0;
    chk("drain_count", 32'(capQ.size()), 32'd4);
    for (int i = 0; i < 4 && i < capQ.size(); i++) chk("drain_order", 32'(capQ[i]), 32'(drainExp[i]));

    // 4. illegal opcode after fresh reset
    doReset(2);
    cycle(1, 16'h8000, 1, 0);
    chk("ill_op", 32'(out_op), 32'd0);
    chk("ill_flag", 32'(out_illegal), 32'd1);
`ifdef DECODE_STATS_EN
    chk("ill_stat_illegal", 32'(stat_illegal), 32'd1);
    chk("ill_stat_instr", stat_instr, 32'd1);
`else
    chk("ill_stat_illegal", 32'(stat_illegal), 32'd0);
    chk("ill_stat_instr", stat_instr, 32'd0);
`endif
    cycle(0, 16'h0, 1, 0);

    // 5. HLT and resume
    cycle(1, 16'h7800, 1, 0);
    chk("hlt_op", 32'(out_op), 32'h0001);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_in_ready", 32'(in_ready), 32'd0);
    cycle(1, 16'h0801, 1, 0);
    chk("hlt_still", 32'(halted), 32'd1);
    cycle(0, 16'h0, 1, 1);
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned r = $urandom_range(0, 19);
      logic [4:0] op = (r < 16) ? 5'(r) : 5'($urandom_range(16, 31));
      logic [15:0] w = {op, 11'($urandom)};
      cycle(($urandom % 4) != 0, w, ($urandom % 10) < 7, ($urandom % 10) == 0);
    end

    // 6. reset while full and halted
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 1);
    cycle(1, 16'h0801, 0, 0);
    cycle(1, 16'h7800, 0, 0);
    chk("full_halted", 32'(halted), 32'd1);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    cycle(0, 16'h0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rst6_out_valid", 32'(out_valid), 32'd0);
    chk("rst6_halted", 32'(halted), 32'd0);
    chk("rst6_stat_instr", stat_instr, 32'd0);
    chk("rst6_stat_illegal", 32'(stat_illegal), 32'd0);
    reset = 1'b0;
    mq.delete();
    mHalt  = 0;
    mInstr = 0;
    mIll   = 0;
    for (int i = 0; i < 3; i++) cycle(0, 16'h0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
